// File: rtl/onehot_strobe_decoder.sv
// rtl/onehot_strobe_decoder.sv - sequential 4:16 one-hot strobe decoder with code FIFO
//
// Purpose: accepts 4-bit codes over a valid/ready handshake, buffers them in a
// circular FIFO and replays each as a one-hot 16-bit strobe held PULSE_LEN
// cycles, followed by GAP_LEN all-zero cycles. Code N drives out[15-N], so the
// numeric value of out is 1 << N and a 16:4 encoder on out returns N.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-high
//   in_code    code to decode, sampled only on a push
//   in_valid   in_code is valid
//   in_ready   FIFO can accept a code this cycle (low while reset is high)
//   out        registered one-hot strobe, zero when idle or in gap
//   out_valid  registered, high exactly while out is non-zero
//   busy       FSM not idle or FIFO non-empty
module onehot_strobe_decoder #(
   parameter int PULSE_LEN  = 4,
   parameter int GAP_LEN    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:3]  in_code,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [0:15] out,
   output logic        out_valid,
   output logic        busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
   localparam logic [7:0]    PULSE_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0]    GAP_LOAD   = 8'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_GAP
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [0:15]    out_q, out_d;
   logic           out_valid_q, out_valid_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [3:0]     mem_q [FIFO_DEPTH];
   logic [3:0]     mem_d [FIFO_DEPTH];

   logic           push;
   logic           pop;
   logic           fifo_empty;
   logic           fifo_full;
   logic [3:0]     head;

   function automatic logic [15:0] onehot(input logic [3:0] code);
      return 16'h0001 << code;
   endfunction

   // in_ready comes from the registered count only: a pop in the same cycle
   // does not reopen a full FIFO, which keeps in_ready free of FSM logic.
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign in_ready   = !fifo_full && !reset;
   assign push       = in_valid && in_ready;
   assign head       = mem_q[rd_ptr_q];

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;

   // Strobe sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      pop         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               out_d       = onehot(head);
               out_valid_d = 1'b1;
               cnt_d       = PULSE_LOAD;
               state_d     = ST_PULSE;
            end
         end

         ST_PULSE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (GAP_LEN > 0) begin
               out_d       = '0;
               out_valid_d = 1'b0;
               cnt_d       = GAP_LOAD;
               state_d     = ST_GAP;
            end else if (!fifo_empty) begin
               // No gap configured: chain straight into the next strobe.
               pop         = 1'b1;
               out_d       = onehot(head);
               out_valid_d = 1'b1;
               cnt_d       = PULSE_LOAD;
            end else begin
               out_d       = '0;
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         ST_GAP: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!fifo_empty) begin
               pop         = 1'b1;
               out_d       = onehot(head);
               out_valid_d = 1'b1;
               cnt_d       = PULSE_LOAD;
               state_d     = ST_PULSE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            out_d       = '0;
            out_valid_d = 1'b0;
            cnt_d       = 8'd0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Code FIFO
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_code;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
      // Storage needs no reset: push is blocked while reset is high and the
      // pointers/count decide which entries are live.
      mem_q <= mem_d;
   end

endmodule
